// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter: serialises s0/s1 onto one downstream port, one transaction at a time.
// Define AXI4_LITE_ARBITER_RR_EN for round-robin contention; the default build uses fixed priority (s0 wins).

package axi4_lite_pkg;
    typedef struct packed {
        int unsigned A;
        int unsigned N;
    } axi4_lite_cfg_t;
endpackage

interface axi4_lite_if #(
    parameter axi4_lite_pkg::axi4_lite_cfg_t C = '{default: 0, A: 16, N: 4}
);
    logic               awvalid;
    logic               awready;
    logic [C.A-1:0]     awaddr;
    logic [2:0]         awprot;
    logic               wvalid;
    logic               wready;
    logic [8*C.N-1:0]   wdata;
    logic [C.N-1:0]     wstrb;
    logic               bvalid;
    logic               bready;
    logic [1:0]         bresp;
    logic               arvalid;
    logic               arready;
    logic [C.A-1:0]     araddr;
    logic [2:0]         arprot;
    logic               rvalid;
    logic               rready;
    logic [8*C.N-1:0]   rdata;
    logic [1:0]         rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

module axi4_lite_arbiter
    import axi4_lite_pkg::*;
#(
    parameter axi4_lite_cfg_t C = '{default: 0, A: 16, N: 4}
) (
    input logic          aclk,
    input logic          aresetn,
    axi4_lite_if.slave   axi4_s0,
    axi4_lite_if.slave   axi4_s1,
    axi4_lite_if.master  axi4_m
);

    // state   | meaning
    // IDLE    | no transaction; arbitrate between requesters
    // WR_AW_W | pass AW and W of granted requester, each tracked by a done flag
    // WR_B    | route write response back to granted requester
    // RD_AR   | pass AR of granted requester
    // RD_R    | route read data back to granted requester
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_g;
    logic   w_g_nxt;
    logic   r_aw_done;
    logic   w_aw_done_nxt;
    logic   r_w_done;
    logic   w_w_done_nxt;

    logic w_req0;
    logic w_req1;
    logic w_pick;
    logic w_aw_act;
    logic w_w_act;
    logic w_b_act;
    logic w_ar_act;
    logic w_r_act;
    logic w_sel_awvalid;
    logic w_sel_wvalid;
    logic w_sel_bready;
    logic w_sel_arvalid;
    logic w_sel_rready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;

    assign w_req0 = axi4_s0.awvalid | axi4_s0.arvalid;
    assign w_req1 = axi4_s1.awvalid | axi4_s1.arvalid;

`ifdef AXI4_LITE_ARBITER_RR_EN
    assign w_pick = (w_req0 & w_req1) ? ~r_g : w_req1;
`else
    assign w_pick = ~w_req0;
`endif

    assign w_aw_act = (r_state == WR_AW_W) & ~r_aw_done;
    assign w_w_act  = (r_state == WR_AW_W) & ~r_w_done;
    assign w_b_act  = (r_state == WR_B);
    assign w_ar_act = (r_state == RD_AR);
    assign w_r_act  = (r_state == RD_R);

    assign w_sel_awvalid = r_g ? axi4_s1.awvalid : axi4_s0.awvalid;
    assign w_sel_wvalid  = r_g ? axi4_s1.wvalid  : axi4_s0.wvalid;
    assign w_sel_bready  = r_g ? axi4_s1.bready  : axi4_s0.bready;
    assign w_sel_arvalid = r_g ? axi4_s1.arvalid : axi4_s0.arvalid;
    assign w_sel_rready  = r_g ? axi4_s1.rready  : axi4_s0.rready;

    assign w_aw_hs = w_aw_act & w_sel_awvalid & axi4_m.awready;
    assign w_w_hs  = w_w_act  & w_sel_wvalid  & axi4_m.wready;
    assign w_b_hs  = w_b_act  & w_sel_bready  & axi4_m.bvalid;
    assign w_ar_hs = w_ar_act & w_sel_arvalid & axi4_m.arready;
    assign w_r_hs  = w_r_act  & w_sel_rready  & axi4_m.rvalid;

    // Downstream: handshake signals gated by state, payload muxed by grant
    assign axi4_m.awvalid = w_aw_act & w_sel_awvalid;
    assign axi4_m.awaddr  = r_g ? axi4_s1.awaddr : axi4_s0.awaddr;
    assign axi4_m.awprot  = r_g ? axi4_s1.awprot : axi4_s0.awprot;
    assign axi4_m.wvalid  = w_w_act & w_sel_wvalid;
    assign axi4_m.wdata   = r_g ? axi4_s1.wdata : axi4_s0.wdata;
    assign axi4_m.wstrb   = r_g ? axi4_s1.wstrb : axi4_s0.wstrb;
    assign axi4_m.bready  = w_b_act & w_sel_bready;
    assign axi4_m.arvalid = w_ar_act & w_sel_arvalid;
    assign axi4_m.araddr  = r_g ? axi4_s1.araddr : axi4_s0.araddr;
    assign axi4_m.arprot  = r_g ? axi4_s1.arprot : axi4_s0.arprot;
    assign axi4_m.rready  = w_r_act & w_sel_rready;

    assign axi4_s0.awready = w_aw_act & ~r_g & axi4_m.awready;
    assign axi4_s0.wready  = w_w_act  & ~r_g & axi4_m.wready;
    assign axi4_s0.bvalid  = w_b_act  & ~r_g & axi4_m.bvalid;
    assign axi4_s0.bresp   = axi4_m.bresp;
    assign axi4_s0.arready = w_ar_act & ~r_g & axi4_m.arready;
    assign axi4_s0.rvalid  = w_r_act  & ~r_g & axi4_m.rvalid;
    assign axi4_s0.rdata   = axi4_m.rdata;
    assign axi4_s0.rresp   = axi4_m.rresp;

    assign axi4_s1.awready = w_aw_act & r_g & axi4_m.awready;
    assign axi4_s1.wready  = w_w_act  & r_g & axi4_m.wready;
    assign axi4_s1.bvalid  = w_b_act  & r_g & axi4_m.bvalid;
    assign axi4_s1.bresp   = axi4_m.bresp;
    assign axi4_s1.arready = w_ar_act & r_g & axi4_m.arready;
    assign axi4_s1.rvalid  = w_r_act  & r_g & axi4_m.rvalid;
    assign axi4_s1.rdata   = axi4_m.rdata;
    assign axi4_s1.rresp   = axi4_m.rresp;

    always_comb begin
        w_state_nxt   = r_state;
        w_g_nxt       = r_g;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    w_g_nxt       = w_pick;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    // write wins over read from the same requester
                    if (w_pick ? axi4_s1.awvalid : axi4_s0.awvalid)
                        w_state_nxt = WR_AW_W;
                    else
                        w_state_nxt = RD_AR;
                end
            end
            WR_AW_W: begin
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done  | w_w_hs;
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_nxt   = WR_B;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end
            WR_B: begin
                if (w_b_hs)
                    w_state_nxt = IDLE;
            end
            RD_AR: begin
                if (w_ar_hs)
                    w_state_nxt = RD_R;
            end
            RD_R: begin
                if (w_r_hs)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_g       <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_g       <= w_g_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

endmodule
